// File: rtl/mii_rx_frame_decoder.sv
// MII receive front end: strips preamble/SFD, assembles bytes low nibble first,
// checks CRC-32, length and alignment, and streams frame bytes with a per-frame
// status strobe. Single clock domain (PHY rx clock), one nibble per cycle.
module mii_rx_frame_decoder #(
  parameter bit          STRIP_FCS            = 1'b1,
  parameter int unsigned MIN_FRAME_BYTES      = 64,
  parameter int unsigned MAX_FRAME_BYTES      = 1518,
  parameter int unsigned MIN_PREAMBLE_NIBBLES = 2
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic [3:0]  i_mii_rx_d,
  input  logic        i_mii_rx_dv,
  input  logic        i_mii_rx_er,
  output logic [7:0]  o_data,
  output logic        o_valid,
  output logic        o_sof,
  output logic        o_done,
  output logic        o_good,
  output logic        o_crc_err,
  output logic        o_align_err,
  output logic        o_phy_err,
  output logic        o_short,
  output logic        o_long,
  output logic [15:0] o_frame_len
);

  localparam logic [15:0] LenMax     = 16'(MAX_FRAME_BYTES);
  localparam logic [15:0] LenSat     = 16'(MAX_FRAME_BYTES + 1);
  localparam logic [15:0] LenMin     = 16'(MIN_FRAME_BYTES);
  localparam logic [7:0]  PreMin     = 8'(MIN_PREAMBLE_NIBBLES);
  localparam logic [31:0] CrcInit    = 32'hFFFF_FFFF;
  localparam logic [31:0] CrcPoly    = 32'hEDB8_8320;
  localparam logic [31:0] CrcResidue = 32'hDEBB_20E3;

  typedef enum logic [1:0] {StIdle, StPreamble, StData, StDrop} state_e;

  // Reflected CRC-32, one byte per update, LSB first.
  function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] b);
    logic [31:0] c;
    c = crc ^ {24'h0, b};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CrcPoly) : (c >> 1);
    end
    return c;
  endfunction

  // Input stage
  logic [3:0] rx_d_q;
  logic       rx_dv_q, rx_er_q;
  // in_valid_q: the input stage holds a real pin sample (not its reset value).
  logic       in_valid_q;

  // Frame state
  state_e      state_q, state_d;
  // armed_q: a genuine dv=0 has been seen since reset, so a dv=1 in IDLE is a
  // real start of frame rather than the tail of a frame cut by reset.
  logic        armed_q, armed_d;
  logic [7:0]  pre_cnt_q, pre_cnt_d;
  logic        phase_q, phase_d;
  logic [3:0]  low_q, low_d;
  logic [31:0] crc_q, crc_d;
  logic [15:0] cnt_q, cnt_d;
  logic        phy_q, phy_d;
  logic [7:0]  dl_q [4];
  logic [7:0]  dl_d [4];

  // Output registers
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        sof_q, sof_d;
  logic        done_q, done_d;
  logic        good_q, good_d;
  logic        crc_err_q, crc_err_d;
  logic        align_err_q, align_err_d;
  logic        phy_err_q, phy_err_d;
  logic        short_q, short_d;
  logic        long_q, long_d;
  logic [15:0] frame_len_q, frame_len_d;

  // Helpers derived from current state
  logic [7:0]  rx_byte;
  logic [15:0] cnt_inc;
  logic        end_crc, end_short, end_long;
  logic [15:0] end_len;

  assign rx_byte   = {rx_d_q, low_q};
  assign cnt_inc   = (cnt_q == LenSat) ? cnt_q : cnt_q + 16'd1;
  assign end_crc   = (crc_q != CrcResidue);
  assign end_short = (cnt_q < LenMin);
  assign end_long  = (cnt_q > LenMax);
  // A long frame reports the saturated count; otherwise the emitted byte count.
  assign end_len   = end_long ? cnt_q :
                     (STRIP_FCS ? ((cnt_q >= 16'd4) ? cnt_q - 16'd4 : 16'd0) : cnt_q);

  // Register the PHY pins once; every decision uses these copies.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      rx_d_q     <= 4'h0;
      rx_dv_q    <= 1'b0;
      rx_er_q    <= 1'b0;
      in_valid_q <= 1'b0;
    end else begin
      rx_d_q     <= i_mii_rx_d;
      rx_dv_q    <= i_mii_rx_dv;
      rx_er_q    <= i_mii_rx_er;
      in_valid_q <= 1'b1;
    end
  end

  // Next-state logic: framing FSM, byte assembly, CRC, delay line and status.
  always_comb begin
    state_d     = state_q;
    armed_d     = armed_q;
    pre_cnt_d   = pre_cnt_q;
    phase_d     = phase_q;
    low_d       = low_q;
    crc_d       = crc_q;
    cnt_d       = cnt_q;
    phy_d       = phy_q;
    dl_d        = dl_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    sof_d       = 1'b0;
    done_d      = 1'b0;
    good_d      = good_q;
    crc_err_d   = crc_err_q;
    align_err_d = align_err_q;
    phy_err_d   = phy_err_q;
    short_d     = short_q;
    long_d      = long_q;
    frame_len_d = frame_len_q;

    case (state_q)
      StIdle: begin
        if (in_valid_q) begin
          if (!rx_dv_q) begin
            armed_d = 1'b1;
          end else if (armed_q && (rx_d_q == 4'h5)) begin
            state_d   = StPreamble;
            pre_cnt_d = 8'd1;
          end else begin
            state_d = StDrop;
          end
        end
      end

      StPreamble: begin
        if (!rx_dv_q) begin
          state_d = StIdle;
        end else if (rx_d_q == 4'h5) begin
          pre_cnt_d = (pre_cnt_q == 8'hFF) ? pre_cnt_q : pre_cnt_q + 8'd1;
        end else if ((rx_d_q == 4'hD) && (pre_cnt_q >= PreMin)) begin
          state_d = StData;
          phase_d = 1'b0;
          crc_d   = CrcInit;
          cnt_d   = 16'd0;
          phy_d   = rx_er_q;  // the SFD cycle counts toward the PHY error flag
        end else begin
          state_d = StDrop;
        end
      end

      StData: begin
        if (!rx_dv_q) begin
          // Frame end; a dangling low nibble is simply discarded.
          state_d     = StIdle;
          phase_d     = 1'b0;
          done_d      = 1'b1;
          crc_err_d   = end_crc;
          align_err_d = phase_q;
          phy_err_d   = phy_q;
          short_d     = end_short;
          long_d      = end_long;
          good_d      = !(end_crc || phase_q || phy_q || end_short || end_long);
          frame_len_d = end_len;
        end else begin
          if (rx_er_q) phy_d = 1'b1;
          if (!phase_q) begin
            low_d   = rx_d_q;
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            crc_d   = crc_byte(crc_q, rx_byte);
            cnt_d   = cnt_inc;
            dl_d[3] = dl_q[2];
            dl_d[2] = dl_q[1];
            dl_d[1] = dl_q[0];
            dl_d[0] = rx_byte;
            if (STRIP_FCS) begin
              // Byte k leaves when byte k+4 completes, so the FCS never leaves.
              if ((cnt_q >= 16'd4) && (cnt_inc <= LenMax)) begin
                valid_d = 1'b1;
                data_d  = dl_q[3];
                sof_d   = (cnt_q == 16'd4);
              end
            end else begin
              if (cnt_inc <= LenMax) begin
                valid_d = 1'b1;
                data_d  = rx_byte;
                sof_d   = (cnt_q == 16'd0);
              end
            end
          end
        end
      end

      StDrop: begin
        if (!rx_dv_q) begin
          state_d = StIdle;
          armed_d = 1'b1;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // State and output registers.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q     <= StIdle;
      armed_q     <= 1'b0;
      pre_cnt_q   <= 8'd0;
      phase_q     <= 1'b0;
      low_q       <= 4'h0;
      crc_q       <= CrcInit;
      cnt_q       <= 16'd0;
      phy_q       <= 1'b0;
      dl_q        <= '{default: 8'h00};
      data_q      <= 8'h00;
      valid_q     <= 1'b0;
      sof_q       <= 1'b0;
      done_q      <= 1'b0;
      good_q      <= 1'b0;
      crc_err_q   <= 1'b0;
      align_err_q <= 1'b0;
      phy_err_q   <= 1'b0;
      short_q     <= 1'b0;
      long_q      <= 1'b0;
      frame_len_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      armed_q     <= armed_d;
      pre_cnt_q   <= pre_cnt_d;
      phase_q     <= phase_d;
      low_q       <= low_d;
      crc_q       <= crc_d;
      cnt_q       <= cnt_d;
      phy_q       <= phy_d;
      dl_q        <= dl_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      sof_q       <= sof_d;
      done_q      <= done_d;
      good_q      <= good_d;
      crc_err_q   <= crc_err_d;
      align_err_q <= align_err_d;
      phy_err_q   <= phy_err_d;
      short_q     <= short_d;
      long_q      <= long_d;
      frame_len_q <= frame_len_d;
    end
  end

  assign o_data      = data_q;
  assign o_valid     = valid_q;
  assign o_sof       = sof_q;
  assign o_done      = done_q;
  assign o_good      = good_q;
  assign o_crc_err   = crc_err_q;
  assign o_align_err = align_err_q;
  assign o_phy_err   = phy_err_q;
  assign o_short     = short_q;
  assign o_long      = long_q;
  assign o_frame_len = frame_len_q;

endmodule

// File: tb/tb_mii_rx_frame_decoder.sv
// Directed bench for mii_rx_frame_decoder: builds frames with a locally computed
// FCS, drives them nibble by nibble and checks the emitted bytes and status.
module tb_mii_rx_frame_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  rx_d;
  logic        rx_dv, rx_er;
  logic [7:0]  o_data;
  logic        o_valid, o_sof, o_done, o_good, o_crc_err, o_align_err;
  logic        o_phy_err, o_short, o_long;
  logic [15:0] o_frame_len;

  mii_rx_frame_decoder #(
    .STRIP_FCS            (1'b1),
    .MIN_FRAME_BYTES      (64),
    .MAX_FRAME_BYTES      (1518),
    .MIN_PREAMBLE_NIBBLES (2)
  ) dut (
    .i_clock     (clk),
    .i_reset     (rst),
    .i_mii_rx_d  (rx_d),
    .i_mii_rx_dv (rx_dv),
    .i_mii_rx_er (rx_er),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .o_sof       (o_sof),
    .o_done      (o_done),
    .o_good      (o_good),
    .o_crc_err   (o_crc_err),
    .o_align_err (o_align_err),
    .o_phy_err   (o_phy_err),
    .o_short     (o_short),
    .o_long      (o_long),
    .o_frame_len (o_frame_len)
  );

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  // Monitor: sampled on the falling edge, away from the active edge.
  logic [7:0]  got [0:8191];
  int          vcount = 0, sofcount = 0, sof_idx = 0, dcount = 0, gcount = 0;
  int          last_valid_cycle = 0, done_cycle = 0;
  logic        s_good, s_crc, s_align, s_phy, s_short, s_long;
  logic [15:0] s_len;

  always @(negedge clk) begin
    if (o_valid) begin
      if (vcount < 8192) got[vcount] = o_data;
      if (o_sof) begin
        sofcount = sofcount + 1;
        sof_idx  = vcount;
      end
      vcount           = vcount + 1;
      last_valid_cycle = cycle;
    end
    if (o_done) begin
      dcount     = dcount + 1;
      if (o_good) gcount = gcount + 1;
      done_cycle = cycle;
      s_good     = o_good;
      s_crc      = o_crc_err;
      s_align    = o_align_err;
      s_phy      = o_phy_err;
      s_short    = o_short;
      s_long     = o_long;
      s_len      = o_frame_len;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // Frame buffer and builders
  logic [7:0] fr [0:2047];
  int         fr_len;

  task automatic push(input logic [7:0] b);
    fr[fr_len] = b;
    fr_len++;
  endtask

  task automatic push_vec(input logic [255:0] v, input int n);
    for (int i = 0; i < n; i++) push(v[8*(n-1-i) +: 8]);
  endtask

  function automatic logic [31:0] crc_upd(input logic [31:0] c_in, input logic [7:0] d);
    logic [31:0] c;
    logic        fb;
    c = c_in;
    for (int b = 0; b < 8; b++) begin
      fb = c[0] ^ d[b];
      c  = c >> 1;
      if (fb) c = c ^ 32'hEDB88320;
    end
    return c;
  endfunction

  task automatic add_fcs();
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < fr_len; i++) c = crc_upd(c, fr[i]);
    c = ~c;
    push(c[7:0]); push(c[15:8]); push(c[23:16]); push(c[31:24]);
  endtask

  task automatic build_arp();
    fr_len = 0;
    push_vec(256'hFFFFFFFFFFFF_080027E95E81_0806, 14);
    push_vec(256'h0001_0800_06_04_0001_080027E95E81_C0A8010A_000000000000_C0A80101, 28);
    while (fr_len < 60) push(8'h00);
    add_fcs();
  endtask

  task automatic build_udp(input int body_len);
    fr_len = 0;
    push_vec(256'h001122334455_080027E95E81_0800, 14);
    push_vec(256'h4500002E_00004000_40110000_C0A8010A_C0A80101, 20);
    push_vec(256'h04D2162E_001A0000, 8);
    while (fr_len < body_len) push(8'(fr_len * 7));
    add_fcs();
  endtask

  task automatic drive(input logic [3:0] d, input logic dv, input logic er);
    rx_d  = d;
    rx_dv = dv;
    rx_er = er;
    @(posedge clk);
    #1;
  endtask

  int         rst_mark_v, rst_mark_d;
  logic       rst_good, rst_valid;
  logic [15:0] rst_len;

  task automatic send_frame(input int er_byte, input bit extra_nib, input int rst_byte,
                            input int gap);
    for (int i = 0; i < 15; i++) drive(4'h5, 1'b1, 1'b0);
    drive(4'hD, 1'b1, 1'b0);
    for (int i = 0; i < fr_len; i++) begin
      if (i == rst_byte) rst = 1'b1;
      drive(fr[i][3:0], 1'b1, (i == er_byte));
      if (i == rst_byte) begin
        rst        = 1'b0;
        rst_mark_v = vcount;
        rst_mark_d = dcount;
        rst_good   = o_good;
        rst_valid  = o_valid;
        rst_len    = o_frame_len;
      end
      drive(fr[i][7:4], 1'b1, 1'b0);
    end
    if (extra_nib) drive(4'h3, 1'b1, 1'b0);
    for (int i = 0; i < gap; i++) drive(4'h0, 1'b0, 1'b0);
  endtask

  int base_v, base_d, base_s, base_g;

  task automatic start_frame();
    base_v = vcount;
    base_d = dcount;
    base_s = sofcount;
    base_g = gcount;
  endtask

  task automatic check_frame(input string nm, input int n, input int good, input int crc,
                             input int align, input int phy, input int shrt, input int lng,
                             input int len, input bit timing);
    int mism;
    mism = 0;
    check({nm, ".nvalid"}, vcount - base_v, n);
    check({nm, ".ndone"}, dcount - base_d, 1);
    check({nm, ".nsof"}, sofcount - base_s, (n > 0) ? 1 : 0);
    if (n > 0) check({nm, ".sofpos"}, sof_idx - base_v, 0);
    for (int i = 0; i < n; i++) if (got[base_v + i] !== fr[i]) mism++;
    check({nm, ".bytes"}, mism, 0);
    check({nm, ".good"}, s_good, good);
    check({nm, ".crc_err"}, s_crc, crc);
    check({nm, ".align_err"}, s_align, align);
    check({nm, ".phy_err"}, s_phy, phy);
    check({nm, ".short"}, s_short, shrt);
    check({nm, ".long"}, s_long, lng);
    check({nm, ".frame_len"}, s_len, len);
    if (timing) check({nm, ".done_lat"}, done_cycle - last_valid_cycle, 1);
  endtask

  initial begin
    rst   = 1'b1;
    rx_d  = 4'h0;
    rx_dv = 1'b0;
    rx_er = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) drive(4'h0, 1'b0, 1'b0);

    // Reset state
    check("reset.valid", o_valid, 0);
    check("reset.done", o_done, 0);
    check("reset.good", o_good, 0);
    check("reset.data", o_data, 0);
    check("reset.frame_len", o_frame_len, 0);

    // Good 64-byte ARP request
    build_arp();
    start_frame();
    send_frame(-1, 1'b0, -1, 8);
    check_frame("arp", 60, 1, 0, 0, 0, 0, 0, 60, 1'b1);
    check("arp.first", got[base_v], 8'hFF);
    check("arp.last", got[base_v + 59], 8'h00);

    // Corrupted payload byte 30
    build_arp();
    fr[30] = fr[30] ^ 8'h01;
    start_frame();
    send_frame(-1, 1'b0, -1, 8);
    check_frame("crc", 60, 0, 1, 0, 0, 0, 0, 60, 1'b1);

    // Trailing odd nibble
    build_arp();
    start_frame();
    send_frame(-1, 1'b1, -1, 8);
    check_frame("align", 60, 0, 0, 1, 0, 0, 0, 60, 1'b0);

    // rx_er for one cycle at byte 20
    build_arp();
    start_frame();
    send_frame(20, 1'b0, -1, 8);
    check_frame("phy", 60, 0, 0, 0, 1, 0, 0, 60, 1'b1);

    // Back-to-back frames with a single idle cycle between them
    build_arp();
    start_frame();
    send_frame(-1, 1'b0, -1, 1);
    send_frame(-1, 1'b0, -1, 8);
    check("b2b.nvalid", vcount - base_v, 120);
    check("b2b.ndone", dcount - base_d, 2);
    check("b2b.ngood", gcount - base_g, 2);

    // Bad preamble, then a good UDP frame
    start_frame();
    drive(4'h5, 1'b1, 1'b0); drive(4'h5, 1'b1, 1'b0);
    drive(4'h5, 1'b1, 1'b0); drive(4'h3, 1'b1, 1'b0);
    drive(4'h5, 1'b1, 1'b0); drive(4'h5, 1'b1, 1'b0); drive(4'h5, 1'b1, 1'b0);
    drive(4'hD, 1'b1, 1'b0); drive(4'h1, 1'b1, 1'b0); drive(4'h2, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) drive(4'h0, 1'b0, 1'b0);
    check("badpre.nvalid", vcount - base_v, 0);
    check("badpre.ndone", dcount - base_d, 0);
    build_udp(60);
    start_frame();
    send_frame(-1, 1'b0, -1, 8);
    check_frame("udp", 60, 1, 0, 0, 0, 0, 0, 60, 1'b1);

    // Reset at byte 30; the remainder carries a fake preamble/SFD that must be ignored
    build_arp();
    for (int i = 30; i < 40; i++) fr[i] = 8'h55;
    fr[40] = 8'hD5;
    for (int i = 41; i < 64; i++) fr[i] = 8'h5D;
    send_frame(-1, 1'b0, 30, 8);
    check("rst.good_clear", rst_good, 0);
    check("rst.valid_clear", rst_valid, 0);
    check("rst.len_clear", rst_len, 0);
    check("rst.nvalid", vcount - rst_mark_v, 0);
    check("rst.ndone", dcount - rst_mark_d, 0);
    build_arp();
    start_frame();
    send_frame(-1, 1'b0, -1, 8);
    check_frame("post_rst", 60, 1, 0, 0, 0, 0, 0, 60, 1'b1);

    // 48-byte frame with valid FCS
    build_udp(44);
    start_frame();
    send_frame(-1, 1'b0, -1, 8);
    check_frame("short", 44, 0, 0, 0, 0, 1, 0, 44, 1'b1);

    // 1530-byte frame
    build_udp(1526);
    start_frame();
    send_frame(-1, 1'b0, -1, 8);
    check_frame("long", 1514, 0, 0, 0, 0, 0, 1, 1519, 1'b0);

    // Status holds after the strobe
    for (int i = 0; i < 5; i++) drive(4'h0, 1'b0, 1'b0);
    check("hold.done", o_done, 0);
    check("hold.long", o_long, 1);
    check("hold.frame_len", o_frame_len, 1519);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
